// File: rtl/d20_pkg.sv
// Shared types and constants for the d20 roller display path.
package d20_pkg;

    localparam int unsigned DIE_W = 5;

    typedef logic [DIE_W-1:0] die_t;

    localparam die_t DIE_MIN = 5'd1;
    localparam die_t DIE_MAX = 5'd20;

    typedef enum logic [1:0] {
        SHOW_LAST = 2'd0,
        SHOW_MAX  = 2'd1,
        SHOW_MIN  = 2'd2,
        SHOW_HIST = 2'd3
    } show_sel_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_e;

    // True when v is a face the die can actually show.
    function automatic logic die_legal(die_t v);
        return (v >= DIE_MIN) && (v <= DIE_MAX);
    endfunction

endpackage

// File: rtl/d20_bin2bcd.sv
// Combinational die value (0..20) to two BCD digits.
// Ports:
//   value_i   die value to convert
//   tens_c_o  tens digit (0..2)
//   ones_c_o  ones digit (0..9)
module d20_bin2bcd
    import d20_pkg::*;
(
    input  die_t       value_i,
    output logic [3:0] tens_c_o,
    output logic [3:0] ones_c_o
);

    logic [4:0] tens_x10_c;

    // Range is tiny, so thresholds beat a general double-dabble.
    always_comb begin
        tens_c_o   = 4'd0;
        tens_x10_c = 5'd0;
        if (value_i >= 5'd20) begin
            tens_c_o   = 4'd2;
            tens_x10_c = 5'd20;
        end else if (value_i >= 5'd10) begin
            tens_c_o   = 4'd1;
            tens_x10_c = 5'd10;
        end
        ones_c_o = 4'(value_i - tens_x10_c);
    end

endmodule

// File: rtl/d20_roll_tracker.sv
// Roll history/statistics tracker with registered BCD display output and
// a crit/fumble blink controller.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   roll_valid      one-cycle strobe qualifying roll_value
//   roll_value      die result, legal 1..20
//   clear           synchronous statistics clear
//   show_sel        display source: last / max / min / history
//   hist_idx        history entry, 0 = most recent
//   bcd_tens/ones   registered digits of the selected value
//   disp_blank      display blanked (blink off phase)
//   crit/fumble     flash active because of a 20 / a 1
//   roll_count      accepted rolls, saturating at 255
//   err_sticky      an illegal value was strobed since reset/clear
module d20_roll_tracker
    import d20_pkg::*;
#(
    parameter int unsigned HIST_DEPTH  = 8,
    parameter int unsigned FLASH_TICKS = 50_000_000,
    parameter int unsigned BLINK_TICKS = 6_250_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          roll_valid,
    input  logic [4:0]                    roll_value,
    input  logic                          clear,
    input  logic [1:0]                    show_sel,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [3:0]                    bcd_tens,
    output logic [3:0]                    bcd_ones,
    output logic                          disp_blank,
    output logic                          crit,
    output logic                          fumble,
    output logic [7:0]                    roll_count,
    output logic                          err_sticky
);

    localparam int unsigned IDX_W   = $clog2(HIST_DEPTH);
    localparam int unsigned FLASH_W = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned CNT_W   = 8;

    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_TICKS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT    = 8'hFF;

    // ---------------- roll qualification ----------------
    logic roll_ok_c;
    logic roll_bad_c;
    logic is_crit_c;
    logic is_fumble_c;

    // clear discards any roll presented in the same cycle
    assign roll_ok_c   = roll_valid && die_legal(roll_value) && !clear;
    assign roll_bad_c  = roll_valid && !die_legal(roll_value);
    assign is_crit_c   = (roll_value == DIE_MAX);
    assign is_fumble_c = (roll_value == DIE_MIN);

    // ---------------- history and statistics ----------------
    die_t              hist_q [HIST_DEPTH];
    logic [IDX_W-1:0]  wr_ptr_q;
    die_t              last_q;
    die_t              max_q;
    die_t              min_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    // History ring, last/max/min, saturating count and sticky error.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist_q   <= '{default: '0};
            wr_ptr_q <= '0;
            last_q   <= '0;
            max_q    <= '0;
            min_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (roll_ok_c) begin
                hist_q[wr_ptr_q] <= roll_value;
                wr_ptr_q         <= wr_ptr_q + IDX_W'(1);
                last_q           <= roll_value;
                if (cnt_q != CNT_SAT) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                // first roll after reset/clear seeds both extremes
                if ((cnt_q == '0) || (roll_value > max_q)) begin
                    max_q <= roll_value;
                end
                if ((cnt_q == '0) || (roll_value < min_q)) begin
                    min_q <= roll_value;
                end
            end
            if (roll_bad_c) begin
                err_q <= 1'b1;
            end
        end
    end

    // ---------------- display source select ----------------
    logic [IDX_W-1:0] rd_ptr_c;
    die_t             sel_val_c;

    // Unwritten slots are zero, so out-of-range indices naturally read 0.
    assign rd_ptr_c = wr_ptr_q - IDX_W'(1) - hist_idx;

    always_comb begin
        sel_val_c = '0;
        case (show_sel_e'(show_sel))
            SHOW_LAST: sel_val_c = last_q;
            SHOW_MAX:  sel_val_c = max_q;
            SHOW_MIN:  sel_val_c = min_q;
            SHOW_HIST: sel_val_c = hist_q[rd_ptr_c];
            default:   sel_val_c = '0;
        endcase
    end

    logic [3:0] tens_c;
    logic [3:0] ones_c;
    logic [3:0] bcd_tens_q;
    logic [3:0] bcd_ones_q;

    d20_bin2bcd u_bin2bcd (
        .value_i  (sel_val_c),
        .tens_c_o (tens_c),
        .ones_c_o (ones_c)
    );

    // Digit register: one cycle behind the tracked state and selectors.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_tens_q <= '0;
            bcd_ones_q <= '0;
        end else begin
            bcd_tens_q <= tens_c;
            bcd_ones_q <= ones_c;
        end
    end

    // ---------------- flash / blink FSM ----------------
    flash_state_e       state_q,     state_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blank_q,     blank_d;
    logic               crit_q,      crit_d;
    logic               fumble_q,    fumble_d;

    // FSM state and flash output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flash_cnt_q <= '0;
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
            crit_q      <= 1'b0;
            fumble_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flash_cnt_q <= flash_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
            crit_q      <= crit_d;
            fumble_q    <= fumble_d;
        end
    end

    // Next state: countdown first, then roll events, then clear override.
    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blank_d     = blank_q;
        crit_d      = crit_q;
        fumble_d    = fumble_q;

        case (state_q)
            IDLE: begin
                blank_d  = 1'b0;
                crit_d   = 1'b0;
                fumble_d = 1'b0;
            end
            FLASH: begin
                if (flash_cnt_q == '0) begin
                    state_d  = IDLE;
                    blank_d  = 1'b0;
                    crit_d   = 1'b0;
                    fumble_d = 1'b0;
                end else begin
                    flash_cnt_d = flash_cnt_q - FLASH_W'(1);
                    if (blink_cnt_q == '0) begin
                        blink_cnt_d = BLINK_LOAD;
                        blank_d     = !blank_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q - BLINK_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (roll_ok_c) begin
            if (is_crit_c || is_fumble_c) begin
                // (re)start the flash with the phase ON
                state_d     = FLASH;
                flash_cnt_d = FLASH_LOAD;
                blink_cnt_d = BLINK_LOAD;
                blank_d     = 1'b0;
                crit_d      = is_crit_c;
                fumble_d    = is_fumble_c;
            end else begin
                // an ordinary roll cancels any flash in progress
                state_d  = IDLE;
                blank_d  = 1'b0;
                crit_d   = 1'b0;
                fumble_d = 1'b0;
            end
        end

        if (clear) begin
            state_d  = IDLE;
            blank_d  = 1'b0;
            crit_d   = 1'b0;
            fumble_d = 1'b0;
        end
    end

    assign bcd_tens   = bcd_tens_q;
    assign bcd_ones   = bcd_ones_q;
    assign disp_blank = blank_q;
    assign crit       = crit_q;
    assign fumble     = fumble_q;
    assign roll_count = cnt_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_d20_roll_tracker.sv
// Bench for d20_roll_tracker: directed stimulus, a behavioural reference
// model compared every cycle, plus literal expectations per scenario.
module tb_d20_roll_tracker;

    localparam int unsigned HD = 8;
    localparam int unsigned FT = 20;
    localparam int unsigned BT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       roll_valid;
    logic [4:0] roll_value;
    logic       clear;
    logic [1:0] show_sel;
    logic [2:0] hist_idx;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       disp_blank;
    logic       crit;
    logic       fumble;
    logic [7:0] roll_count;
    logic       err_sticky;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    d20_roll_tracker #(
        .HIST_DEPTH  (HD),
        .FLASH_TICKS (FT),
        .BLINK_TICKS (BT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .roll_valid (roll_valid),
        .roll_value (roll_value),
        .clear      (clear),
        .show_sel   (show_sel),
        .hist_idx   (hist_idx),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones),
        .disp_blank (disp_blank),
        .crit       (crit),
        .fumble     (fumble),
        .roll_count (roll_count),
        .err_sticky (err_sticky)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_hist[$];      // most recent roll at index 0
    int m_last, m_max, m_min, m_count, m_disp;
    bit m_err;
    bit m_active;
    int m_cause, m_age;

    function automatic int m_select(input int sel, input int idx);
        case (sel)
            0:       return m_last;
            1:       return m_max;
            2:       return m_min;
            default: return (idx < m_hist.size()) ? m_hist[idx] : 0;
        endcase
    endfunction

    task automatic m_wipe();
        m_hist.delete();
        m_last = 0; m_max = 0; m_min = 0; m_count = 0;
        m_err = 1'b0; m_active = 1'b0; m_age = 0; m_cause = 0;
    endtask

    initial forever begin
        int v;
        bit legal;
        @(posedge clk);
        v = int'(roll_value);
        legal = (v >= 1) && (v <= 20);
        if (reset) begin
            m_disp = 0;
            m_wipe();
        end else begin
            m_disp = m_select(int'(show_sel), int'(hist_idx));
            if (clear) begin
                m_wipe();
            end else begin
                if (roll_valid && !legal) m_err = 1'b1;
                if (roll_valid && legal) begin
                    m_hist.push_front(v);
                    if (m_hist.size() > HD) void'(m_hist.pop_back());
                    m_max = (m_count == 0 || v > m_max) ? v : m_max;
                    m_min = (m_count == 0 || v < m_min) ? v : m_min;
                    m_last = v;
                    if (m_count < 255) m_count++;
                    if (v == 20 || v == 1) begin
                        m_active = 1'b1; m_age = 0; m_cause = v;
                    end else begin
                        m_active = 1'b0;
                    end
                end else if (m_active) begin
                    m_age++;
                    if (m_age >= int'(FT)) m_active = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("m_tens",   32'(bcd_tens),   32'(m_disp / 10));
            check("m_ones",   32'(bcd_ones),   32'(m_disp % 10));
            check("m_blank",  32'(disp_blank), 32'(m_active && ((m_age / int'(BT)) % 2 == 1)));
            check("m_crit",   32'(crit),       32'(m_active && m_cause == 20));
            check("m_fumble", 32'(fumble),     32'(m_active && m_cause == 1));
            check("m_count",  32'(roll_count), 32'(m_count));
            check("m_err",    32'(err_sticky), 32'(m_err));
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic do_roll(input int v);
        roll_valid = 1'b1;
        roll_value = 5'(v);
        @(negedge clk);
        roll_valid = 1'b0;
        roll_value = 5'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [19:0] blink_pat;

    initial begin
        reset = 1'b1; clear = 1'b0; roll_valid = 1'b0; roll_value = 5'd0;
        show_sel = 2'd0; hist_idx = 3'd0;
        blink_pat = 20'b0000_1111_0000_1111_0000;
        repeat (3) @(negedge clk);

        // 1: reset state
        check("t1_tens", 32'(bcd_tens), 32'd0);
        check("t1_ones", 32'(bcd_ones), 32'd0);
        check("t1_blank", 32'(disp_blank), 32'd0);
        check("t1_count", 32'(roll_count), 32'd0);
        check("t1_err", 32'(err_sticky), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // 2: last/max/min and one-cycle display latency
        do_roll(7);
        check("t2_lat_ones", 32'(bcd_ones), 32'd0);
        @(negedge clk);
        check("t2_upd_ones", 32'(bcd_ones), 32'd7);
        do_roll(14);
        do_roll(3);
        @(negedge clk);
        check("t2_last_tens", 32'(bcd_tens), 32'd0);
        check("t2_last_ones", 32'(bcd_ones), 32'd3);
        show_sel = 2'd1;
        @(negedge clk);
        check("t2_max_tens", 32'(bcd_tens), 32'd1);
        check("t2_max_ones", 32'(bcd_ones), 32'd4);
        show_sel = 2'd2;
        @(negedge clk);
        check("t2_min_tens", 32'(bcd_tens), 32'd0);
        check("t2_min_ones", 32'(bcd_ones), 32'd3);
        check("t2_count", 32'(roll_count), 32'd3);

        // 3: history wrap
        do_reset();
        show_sel = 2'd3; hist_idx = 3'd0;
        do_roll(1);
        check("t3_fumble", 32'(fumble), 32'd1);
        check("t3_crit", 32'(crit), 32'd0);
        for (int v = 2; v <= 9; v++) do_roll(v);
        check("t3_fumble_gone", 32'(fumble), 32'd0);
        @(negedge clk);
        check("t3_h0_ones", 32'(bcd_ones), 32'd9);
        hist_idx = 3'd7;
        @(negedge clk);
        check("t3_h7_tens", 32'(bcd_tens), 32'd0);
        check("t3_h7_ones", 32'(bcd_ones), 32'd2);
        check("t3_count", 32'(roll_count), 32'd9);

        // 4: crit flash blink pattern
        do_reset();
        show_sel = 2'd0; hist_idx = 3'd0;
        do_roll(20);
        for (int i = 0; i < 20; i++) begin
            check("t4_crit", 32'(crit), 32'd1);
            check("t4_blank", 32'(disp_blank), 32'(blink_pat[19 - i]));
            @(negedge clk);
        end
        check("t4_crit_end", 32'(crit), 32'd0);
        check("t4_blank_end", 32'(disp_blank), 32'd0);

        // 5: illegal strobes and clear
        do_reset();
        do_roll(0);
        check("t5_err_set", 32'(err_sticky), 32'd1);
        check("t5_count0", 32'(roll_count), 32'd0);
        do_roll(21);
        do_roll(5);
        check("t5_count1", 32'(roll_count), 32'd1);
        check("t5_err_held", 32'(err_sticky), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t5_err_clr", 32'(err_sticky), 32'd0);
        check("t5_count_clr", 32'(roll_count), 32'd0);

        // 6: abort flash, then reset+clear+roll together
        do_reset();
        do_roll(20);
        check("t6_crit_on", 32'(crit), 32'd1);
        do_roll(12);
        check("t6_crit_abort", 32'(crit), 32'd0);
        check("t6_blank_abort", 32'(disp_blank), 32'd0);
        reset = 1'b1; clear = 1'b1; roll_valid = 1'b1; roll_value = 5'd15;
        @(negedge clk);
        reset = 1'b0; clear = 1'b0; roll_valid = 1'b0; roll_value = 5'd0;
        check("t6_tens", 32'(bcd_tens), 32'd0);
        check("t6_ones", 32'(bcd_ones), 32'd0);
        check("t6_count", 32'(roll_count), 32'd0);
        check("t6_err", 32'(err_sticky), 32'd0);
        check("t6_crit", 32'(crit), 32'd0);
        check("t6_fumble", 32'(fumble), 32'd0);
        check("t6_blank", 32'(disp_blank), 32'd0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
